// File: rtl/pwm_decoder.sv
// -----------------------------------------------------------------------------
// pwm_decoder
//
// Measures a motor PWM waveform in prescaled ticks and reports its period, its
// high time and a coarse duty code. It also flags a waveform that has stopped
// toggling and forwards a synchronised copy of the direction line.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   pwm_in       in   asynchronous PWM waveform
//   dir_in       in   asynchronous direction line
//   duty_code    out  2-bit duty: 00 ~0%, 01 ~25%, 10 ~50%, 11 ~75%+
//   high_cnt     out  ticks high in the last complete period
//   period_cnt   out  ticks between the last two rising edges
//   valid        out  one-clk pulse when the three measurements update
//   dir_out      out  synchronised dir_in
//   stuck        out  no usable pwm_in edge for TIMEOUT ticks
//   stuck_level  out  pwm_in level while stuck is asserted
//
// Handshake: valid is a one-cycle strobe with no ready; duty_code, high_cnt and
// period_cnt change only in the cycle valid is high and hold otherwise.
// -----------------------------------------------------------------------------
module pwm_decoder #(
    parameter int unsigned PRESC   = 8,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 12'hFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             dir_in,
    output logic [1:0]       duty_code,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             dir_out,
    output logic             stuck,
    output logic             stuck_level
);

    localparam int unsigned      MW        = CNT_W + 3;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } state_e;

    state_e state_q, state_d;

    // synchronisers and edge detect
    logic pwm_s1_q, pwm_s2_q, pwm_s3_q;
    logic dir_s1_q, dir_s2_q;
    logic rise, fall;

    // prescaler
    logic [PRESC-1:0] presc_q, presc_d;
    logic             tick;

    // measurement datapath
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] high_reg_q, high_reg_d;
    logic             hvalid_q, hvalid_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cap_high_q, cap_high_d;
    logic [CNT_W-1:0] cap_period_q, cap_period_d;

    // registered outputs
    logic [1:0]       duty_q, duty_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;

    // duty arithmetic
    logic [MW-1:0] h8, p1, p3, p5;
    logic [1:0]    duty_calc;

    // ------------------------------------------------------------------
    // Synchronisers: pwm gets a third flop purely for edge detection.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_s1_q <= 1'b0;
            pwm_s2_q <= 1'b0;
            pwm_s3_q <= 1'b0;
            dir_s1_q <= 1'b0;
            dir_s2_q <= 1'b0;
        end else begin
            pwm_s1_q <= pwm_in;
            pwm_s2_q <= pwm_s1_q;
            pwm_s3_q <= pwm_s2_q;
            dir_s1_q <= dir_in;
            dir_s2_q <= dir_s1_q;
        end
    end

    assign rise = pwm_s2_q & ~pwm_s3_q;
    assign fall = ~pwm_s2_q & pwm_s3_q;

    // ------------------------------------------------------------------
    // Free-running prescaler; the tick is an enable, never a clock, and
    // edges do not restart it.
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q + 1'b1;
    end

    assign tick = &presc_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Edges win over the timeout in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise)                     state_d = ST_HIGH;
                else if (run_q == TIMEOUT_C)  state_d = ST_STUCK;
            end
            ST_HIGH: begin
                if (fall)                     state_d = ST_LOW;
                else if (run_q == TIMEOUT_C)  state_d = ST_STUCK;
            end
            ST_LOW: begin
                if (rise)                     state_d = ST_HIGH;
                else if (run_q == TIMEOUT_C)  state_d = ST_STUCK;
            end
            ST_STUCK: begin
                if (rise)                     state_d = ST_HIGH;
                else if (fall)                state_d = ST_LOW;
            end
            default:                          state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. stuck_level is captured on entry to STUCK and held.
    // ------------------------------------------------------------------
    always_comb begin
        stuck_d       = (state_d == ST_STUCK);
        stuck_level_d = stuck_level_q;
        if (state_d != ST_STUCK) begin
            stuck_level_d = 1'b0;
        end else if (state_q != ST_STUCK) begin
            stuck_level_d = pwm_s2_q;
        end
    end

    // ------------------------------------------------------------------
    // Measurement datapath.
    // The run counter spans rise to rise so it measures the period; the fall
    // only snapshots it as the high time. In IDLE/STUCK any edge restarts it,
    // otherwise a fall out of STUCK would land in LOW already timed out.
    // hvalid_q records that the current LOW phase followed a measured HIGH
    // phase; without it the next rise has no trustworthy high time.
    // ------------------------------------------------------------------
    always_comb begin
        run_d        = run_q;
        high_reg_d   = high_reg_q;
        hvalid_d     = hvalid_q;
        pend_d       = 1'b0;
        cap_high_d   = cap_high_q;
        cap_period_d = cap_period_q;

        if (rise || (fall && (state_q == ST_IDLE || state_q == ST_STUCK))) begin
            run_d = '0;
        end else if (tick && (run_q != TIMEOUT_C)) begin
            run_d = run_q + 1'b1;
        end

        if (state_q == ST_HIGH && fall) begin
            high_reg_d = run_q;
            hvalid_d   = 1'b1;
        end else if (rise || state_q == ST_STUCK) begin
            hvalid_d   = 1'b0;
        end

        if (state_q == ST_LOW && rise && hvalid_q) begin
            pend_d       = 1'b1;
            cap_high_d   = high_reg_q;
            cap_period_d = run_q;
        end
    end

    // Duty thresholds at full width: 8*high against 1x, 3x, 5x period.
    always_comb begin
        h8 = {cap_high_q, 3'b000};
        p1 = MW'(cap_period_q);
        p3 = p1 + (p1 << 1);
        p5 = p1 + (p1 << 2);
        if (h8 < p1)      duty_calc = 2'b00;
        else if (h8 < p3) duty_calc = 2'b01;
        else if (h8 < p5) duty_calc = 2'b10;
        else              duty_calc = 2'b11;
    end

    // Output stage: a zero period is meaningless and is dropped silently.
    always_comb begin
        duty_d       = duty_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        if (pend_q && (cap_period_q != '0)) begin
            duty_d       = duty_calc;
            high_cnt_d   = cap_high_q;
            period_cnt_d = cap_period_q;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            run_q         <= '0;
            high_reg_q    <= '0;
            hvalid_q      <= 1'b0;
            pend_q        <= 1'b0;
            cap_high_q    <= '0;
            cap_period_q  <= '0;
            duty_q        <= 2'b00;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            run_q         <= run_d;
            high_reg_q    <= high_reg_d;
            hvalid_q      <= hvalid_d;
            pend_q        <= pend_d;
            cap_high_q    <= cap_high_d;
            cap_period_q  <= cap_period_d;
            duty_q        <= duty_d;
            high_cnt_q    <= high_cnt_d;
            period_cnt_q  <= period_cnt_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign duty_code   = duty_q;
    assign high_cnt    = high_cnt_q;
    assign period_cnt  = period_cnt_q;
    assign valid       = valid_q;
    assign dir_out     = dir_s2_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule
